mdio_master: RTL and testbench

Parametrised MDIO (IEEE 802.3 management) master. Generates MDC from the system clock and serialises one management frame per accepted request. Supports Clause 22 and Clause 45 framing, configurable preamble length, and read-turnaround error detection. Sits between a register-access controller (CPU bridge or init sequencer) and the PHY pins; the tristate pad is instantiated at top level from mdio_o/mdio_oe/mdio_i.

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_master_if.sv | 25 ++
 rtl/mdio_tick_gen.sv | 37 +++
 rtl/mdio_master.sv | 148 ++++++++++++++
 tb/tb_mdio_master.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, FSM state type and request decode helper.
package mdio_pkg;

   localparam logic [1:0] ST_CL22     = 2'b01;
   localparam logic [1:0] ST_CL45     = 2'b00;

   localparam logic [1:0] OP22_WR     = 2'b01;
   localparam logic [1:0] OP22_RD     = 2'b10;
   localparam logic [1:0] OP45_ADDR   = 2'b00;
   localparam logic [1:0] OP45_WR     = 2'b01;
   localparam logic [1:0] OP45_RD_INC = 2'b10;
   localparam logic [1:0] OP45_RD     = 2'b11;

   localparam logic [1:0] TA_DRIVE    = 2'b10;

   localparam int HDR_BITS  = 14;
   localparam int TA_BITS   = 2;
   localparam int DATA_BITS = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   function automatic logic is_read(input logic cl45, input logic [1:0] op);
      return cl45 ? (op == OP45_RD || op == OP45_RD_INC) : (op == OP22_RD);
   endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Request/response bus between a register-access controller and the MDIO master.
interface mdio_master_if;

   logic        op_valid;
   logic        op_ready;
   logic        op_cl45;
   logic [1:0]  op_code;
   logic [4:0]  op_phya;
   logic [4:0]  op_rega;
   logic [15:0] op_din;
   logic [15:0] op_dout;
   logic        op_done;
   logic        op_err;

   modport master (
      output op_valid, op_cl45, op_code, op_phya, op_rega, op_din,
      input  op_ready, op_dout, op_done, op_err
   );

   modport slave (
      input  op_valid, op_cl45, op_code, op_phya, op_rega, op_din,
      output op_ready, op_dout, op_done, op_err
   );

endinterface

// File: rtl/mdio_tick_gen.sv
// MDC phase divider: flags the last cycle of each MDC half-period so the FSM
// acts on the following edge (rise_tick -> MDC goes high, fall_tick -> next bit).
module mdio_tick_gen #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic fall_tick,
   output logic rise_tick
);

   localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] cnt;
   logic         high;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         high <= 1'b0;
      end else if (restart) begin
         cnt  <= '0;
         high <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         high <= ~high;
      end else begin
         cnt  <= cnt + W'(1);
      end
   end

   assign rise_tick = !high && (cnt == LAST);
   assign fall_tick =  high && (cnt == LAST);

endmodule

// File: rtl/mdio_master.sv
// MDIO management master: one Clause 22/45 frame per accepted request, with
// registered pin outputs and read-turnaround error detection.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int DIV     = 1000,
   parameter int PRE_LEN = 32,
   parameter int CL45_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mdc,
   output logic          mdio_o,
   output logic          mdio_oe,
   input  logic          mdio_i,
   mdio_master_if.slave  bus
);

   localparam logic [5:0] PRE_LAST  = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
   localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
   localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
   localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

   state_t       state;
   logic [5:0]   cnt;
   logic [31:0]  sr;
   logic [15:0]  rd_sr;
   logic         rd;
   logic         ta_err;

   logic         accept;
   logic         reject;
   logic         fall_tick;
   logic         rise_tick;
   logic [31:0]  frame;

   assign accept = bus.op_valid && bus.op_ready;
   assign reject = bus.op_cl45 && (CL45_EN == 0);
   assign frame  = {bus.op_cl45 ? ST_CL45 : ST_CL22, bus.op_code,
                    bus.op_phya, bus.op_rega, TA_DRIVE, bus.op_din};

   mdio_tick_gen #(.DIV(DIV)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart   (accept),
      .fall_tick (fall_tick),
      .rise_tick (rise_tick)
   );

   // NOTE: all state and pin outputs use non-blocking assignments so every
   // register updates from pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         mdc         <= 1'b0;
         mdio_o      <= 1'b1;
         mdio_oe     <= 1'b0;
         bus.op_ready <= 1'b1;
         bus.op_dout <= '0;
         bus.op_done <= 1'b0;
         bus.op_err  <= 1'b0;
         cnt         <= '0;
         sr          <= '0;
         rd_sr       <= '0;
         rd          <= 1'b0;
         ta_err      <= 1'b0;
      end else begin
         bus.op_done <= 1'b0;
         bus.op_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  bus.op_ready <= 1'b0;
                  rd           <= is_read(bus.op_cl45, bus.op_code);
                  ta_err       <= 1'b0;
                  if (reject) begin
                     bus.op_done <= 1'b1;
                     bus.op_err  <= 1'b1;
                     state       <= S_DONE;
                  end else if (PRE_LEN > 0) begin
                     state   <= S_PRE;
                     cnt     <= PRE_LAST;
                     mdio_o  <= 1'b1;
                     mdio_oe <= 1'b1;
                     sr      <= frame;
                  end else begin
                     state   <= S_HDR;
                     cnt     <= HDR_LAST;
                     mdio_o  <= frame[31];
                     mdio_oe <= 1'b1;
                     sr      <= {frame[30:0], 1'b0};
                  end
               end
            end

            S_DONE: begin
               bus.op_ready <= 1'b1;
               state        <= S_IDLE;
            end

            default: begin
               if (rise_tick) begin
                  mdc <= 1'b1;
                  if (state == S_TA && cnt == '0) ta_err <= mdio_i;
                  if (state == S_DATA) rd_sr <= {rd_sr[14:0], mdio_i};
               end
               if (fall_tick) begin
                  mdc <= 1'b0;
                  if (state == S_DATA && cnt == '0) begin
                     state       <= S_DONE;
                     bus.op_done <= 1'b1;
                     bus.op_err  <= rd && ta_err;
                     if (rd) bus.op_dout <= rd_sr;
                     mdio_oe     <= 1'b0;
                     mdio_o      <= 1'b1;
                  end else begin
                     // Preamble holds the line at '1'; every other bit shifts out MSB first.
                     if (state != S_PRE || cnt == '0) begin
                        mdio_o <= sr[31];
                        sr     <= {sr[30:0], 1'b0};
                     end
                     if (cnt != '0) begin
                        cnt <= cnt - 6'd1;
                     end else begin
                        case (state)
                           S_PRE: begin
                              state <= S_HDR;
                              cnt   <= HDR_LAST;
                           end
                           S_HDR: begin
                              state   <= S_TA;
                              cnt     <= TA_LAST;
                              mdio_oe <= !rd;
                           end
                           default: begin
                              state <= S_DATA;
                              cnt   <= DATA_LAST;
                           end
                        endcase
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: three configurations (full preamble, no
// preamble, Clause 45 disabled) sharing one clock, with a small PHY read model.
module tb_mdio_master;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Shared request fields; op_valid is steered to one instance by sel.
   int          sel = 0;
   logic        req_valid = 1'b0;
   logic        req_cl45  = 1'b0;
   logic [1:0]  req_code  = '0;
   logic [4:0]  req_phya  = '0;
   logic [4:0]  req_rega  = '0;
   logic [15:0] req_din   = '0;

   mdio_master_if bus0 ();
   mdio_master_if bus1 ();
   mdio_master_if bus2 ();

   assign bus0.op_valid = req_valid && (sel == 0);
   assign bus1.op_valid = req_valid && (sel == 1);
   assign bus2.op_valid = req_valid && (sel == 2);
   assign {bus0.op_cl45, bus0.op_code, bus0.op_phya, bus0.op_rega, bus0.op_din} =
          {req_cl45, req_code, req_phya, req_rega, req_din};
   assign {bus1.op_cl45, bus1.op_code, bus1.op_phya, bus1.op_rega, bus1.op_din} =
          {req_cl45, req_code, req_phya, req_rega, req_din};
   assign {bus2.op_cl45, bus2.op_code, bus2.op_phya, bus2.op_rega, bus2.op_din} =
          {req_cl45, req_code, req_phya, req_rega, req_din};

   logic mdc0, mdo0, moe0, mdi0;
   logic mdc1, mdo1, moe1;
   logic mdc2, mdo2, moe2;

   mdio_master #(.DIV(4), .PRE_LEN(32), .CL45_EN(1)) u_dut0 (
      .clk(clk), .rst(rst), .mdc(mdc0), .mdio_o(mdo0), .mdio_oe(moe0), .mdio_i(mdi0), .bus(bus0));
   mdio_master #(.DIV(4), .PRE_LEN(0), .CL45_EN(1)) u_dut1 (
      .clk(clk), .rst(rst), .mdc(mdc1), .mdio_o(mdo1), .mdio_oe(moe1), .mdio_i(1'b1), .bus(bus1));
   mdio_master #(.DIV(4), .PRE_LEN(32), .CL45_EN(0)) u_dut2 (
      .clk(clk), .rst(rst), .mdc(mdc2), .mdio_o(mdo2), .mdio_oe(moe2), .mdio_i(1'b1), .bus(bus2));

   // Pin capture at each MDC rising edge, indexed by a free-running bit counter.
   logic cap_o0 [0:1023];
   logic cap_oe0[0:1023];
   logic cap_o1 [0:1023];
   int   n0 = 0, n1 = 0, n2 = 0;
   int   base0 = 0, base1 = 0, base2 = 0;

   always @(posedge mdc0) begin
      cap_o0[n0 & 1023]  = mdo0;
      cap_oe0[n0 & 1023] = moe0;
      n0 = n0 + 1;
   end
   always @(posedge mdc1) begin
      cap_o1[n1 & 1023] = mdo1;
      n1 = n1 + 1;
   end
   always @(posedge mdc2) n2 = n2 + 1;

   // PHY model: drives the value for the next bit after each MDC falling edge.
   logic        phy_en   = 1'b0;
   logic        phy_ta   = 1'b0;
   logic [15:0] phy_data = '0;
   logic        phy_drv  = 1'b1;
   assign mdi0 = phy_en ? phy_drv : 1'b1;

   always @(negedge mdc0) begin
      int nxt;
      nxt = n0 - base0;
      if (nxt == 47)                    phy_drv = phy_ta;
      else if (nxt >= 48 && nxt <= 63)  phy_drv = phy_data[63 - nxt];
      else                              phy_drv = 1'b1;
   end

   int dc0 = 0, dc1 = 0;
   always @(posedge clk) begin
      if (bus0.op_done) dc0 <= dc0 + 1;
      if (bus1.op_done) dc1 <= dc1 + 1;
   end

   function automatic logic cur_ready();
      case (sel)
         0:       return bus0.op_ready;
         1:       return bus1.op_ready;
         default: return bus2.op_ready;
      endcase
   endfunction
   function automatic logic cur_done();
      case (sel)
         0:       return bus0.op_done;
         1:       return bus1.op_done;
         default: return bus2.op_done;
      endcase
   endfunction
   function automatic logic cur_err();
      case (sel)
         0:       return bus0.op_err;
         1:       return bus1.op_err;
         default: return bus2.op_err;
      endcase
   endfunction

   function automatic logic [63:0] bits0(input int first, input int len, input bit want_oe);
      logic [63:0] v = '0;
      for (int k = 0; k < len; k++) begin
         v = {v[62:0], want_oe ? cap_oe0[(base0 + first + k) & 1023] : cap_o0[(base0 + first + k) & 1023]};
      end
      return v;
   endfunction
   function automatic logic [63:0] bits1(input int first, input int len);
      logic [63:0] v = '0;
      for (int k = 0; k < len; k++) v = {v[62:0], cap_o1[(base1 + first + k) & 1023]};
      return v;
   endfunction

   int acc_cyc = 0;

   task automatic start_op(input int s, input logic cl45, input logic [1:0] code,
                           input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] din);
      sel      = s;
      req_cl45 = cl45;
      req_code = code;
      req_phya = pa;
      req_rega = ra;
      req_din  = din;
      check("ready_idle", cur_ready(), 1'b1);
      base0 = n0;
      base1 = n1;
      base2 = n2;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, input bit inject, output int lat, output logic err);
      int i = 0;
      while (!cur_done() && i < budget) begin
         if (inject && i == 50)  req_valid = 1'b1;
         if (inject && i == 100) req_valid = 1'b0;
         @(posedge clk); #1;
         i++;
      end
      req_valid = 1'b0;
      if (!cur_done()) begin
         check("done_timeout", 64'(i), 64'(budget + 1));
         lat = -1;
         err = 1'bx;
      end else begin
         lat = cyc - acc_cyc;
         err = cur_err();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int   lat;
      logic err;
      int   snap;

      #1 rst = 1'b1;
      #1;
      check("reset_pins", {mdc0, mdo0, moe0, bus0.op_ready, bus0.op_done, bus0.op_err}, 6'b010100);
      check("reset_dout", bus0.op_dout, 16'h0000);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // CL22 write
      start_op(0, 1'b0, 2'b01, 5'h01, 5'h00, 16'h8000);
      check("busy_not_ready", bus0.op_ready, 1'b0);
      wait_done(2000, 1'b0, lat, err);
      check("wr_latency", 64'(lat), 64'd512);
      check("wr_err", err, 1'b0);
      check("wr_mdc_count", 64'(n0 - base0), 64'd64);
      check("wr_preamble", bits0(0, 32, 0), 64'hFFFF_FFFF);
      check("wr_frame", bits0(32, 32, 0), 64'h5082_8000);
      check("wr_oe", bits0(0, 64, 1), 64'hFFFF_FFFF_FFFF_FFFF);

      // CL22 read with PHY answering 0x1234
      phy_en = 1'b1; phy_ta = 1'b0; phy_data = 16'h1234;
      start_op(0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000);
      wait_done(2000, 1'b0, lat, err);
      check("rd_latency", 64'(lat), 64'd512);
      check("rd_hdr", bits0(32, 14, 0), 64'h1822);
      check("rd_oe", bits0(0, 64, 1), 64'hFFFF_FFFF_FFFC_0000);
      check("rd_dout", bus0.op_dout, 16'h1234);
      check("rd_err", err, 1'b0);

      // CL22 read with no PHY
      phy_en = 1'b0;
      start_op(0, 1'b0, 2'b10, 5'h07, 5'h01, 16'h0000);
      wait_done(2000, 1'b0, lat, err);
      check("nophy_dout", bus0.op_dout, 16'hFFFF);
      check("nophy_err", err, 1'b1);

      // CL45 address frame, then CL45 read
      start_op(0, 1'b1, 2'b00, 5'h03, 5'h01, 16'h0010);
      wait_done(2000, 1'b0, lat, err);
      check("c45a_frame", bits0(32, 32, 0), 64'h0186_0010);
      check("c45a_err", err, 1'b0);
      phy_en = 1'b1; phy_ta = 1'b0; phy_data = 16'hBEEF;
      start_op(0, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000);
      wait_done(2000, 1'b0, lat, err);
      check("c45r_st", bits0(32, 2, 0), 64'h0);
      check("c45r_op", bits0(34, 2, 0), 64'h3);
      check("c45r_dout", bus0.op_dout, 16'hBEEF);
      check("c45r_err", err, 1'b0);

      // Reset at bit 20 of a read
      phy_data = 16'h5555;
      start_op(0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000);
      for (int i = 0; i < 2000 && (n0 - base0) < 20; i++) begin
         @(posedge clk); #1;
      end
      check("rst_reached_bit20", 64'(n0 - base0), 64'd20);
      snap = dc0;
      rst = 1'b1;
      #1;
      check("rst_mid_pins", {mdc0, mdo0, moe0, bus0.op_ready, bus0.op_done, bus0.op_err}, 6'b010100);
      check("rst_mid_dout", bus0.op_dout, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rst_no_done", 64'(dc0 - snap), 64'd0);
      start_op(0, 1'b0, 2'b01, 5'h02, 5'h03, 16'h00FF);
      wait_done(2000, 1'b0, lat, err);
      check("post_rst_latency", 64'(lat), 64'd512);
      check("post_rst_err", err, 1'b0);
      phy_en = 1'b0;

      // CL45 request with Clause 45 disabled
      start_op(2, 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000);
      check("c45off_done_t1", bus2.op_done, 1'b1);
      check("c45off_err", bus2.op_err, 1'b1);
      wait_done(100, 1'b0, lat, err);
      check("c45off_latency", 64'(lat), 64'd0);
      check("c45off_ready_back", bus2.op_ready, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("c45off_no_mdc", 64'(n2 - base2), 64'd0);
      check("c45off_no_oe", moe2, 1'b0);

      // No-preamble write with a stray request while busy
      snap = dc1;
      start_op(1, 1'b0, 2'b01, 5'h01, 5'h00, 16'hA5A5);
      wait_done(2000, 1'b1, lat, err);
      repeat (5) @(posedge clk);
      #1;
      check("np_latency", 64'(lat), 64'd256);
      check("np_mdc_count", 64'(n1 - base1), 64'd32);
      check("np_frame", bits1(0, 32), 64'h5082_A5A5);
      check("np_one_done", 64'(dc1 - snap), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
